// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Which requester owns the memory port.
  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } arb_gnt_e;

  // The requester that is not g.
  function automatic arb_gnt_e other_gnt(input arb_gnt_e g);
    return (g == GNT_INST) ? GNT_DATA : GNT_INST;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational tie-break between fetch and mem-stage requests.
// With no request pending the output is don't-care (reports data).
module arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic     inst_req,
  input  logic     data_req,
  input  arb_gnt_e last_winner,
  output arb_gnt_e winner
);

  // Lone requester wins; on a tie data wins unless alternating is enabled.
  always_comb begin
    winner = GNT_DATA;
    if (inst_req && !data_req) begin
      winner = GNT_INST;
    end else if (inst_req && data_req && (ROUND_ROBIN != 0)) begin
      winner = other_gnt(last_winner);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the
// mem-stage load/store path. One transaction at a time: pick, present the
// address until accepted, then wait for the data/completion beat.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no transaction; pick a winner among pending requests
//   ADDR  | mem_req high with latched payload, waiting for mem_addr_ok
//   DATA  | request accepted, waiting for mem_data_ok to finish
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int ROUND_ROBIN = 0
) (
  input  logic            clk,
  input  logic            rst,
  // fetch side
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_ok,
  // mem-stage side
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_ok,
  // memory side
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata,
  // hazard unit
  output logic            stall_inst,
  output logic            stall_data
);

  localparam int SW = DW / 8;

  arb_state_e      state_q, state_d;
  arb_gnt_e        grant_q, grant_d;
  arb_gnt_e        last_winner_q, last_winner_d;
  arb_gnt_e        pick;

  logic            lat_wr_q, lat_wr_d;
  logic [SW-1:0]   lat_wstrb_q, lat_wstrb_d;
  logic [AW-1:0]   lat_addr_q, lat_addr_d;
  logic [DW-1:0]   lat_wdata_q, lat_wdata_d;

  logic [DW-1:0]   inst_rdata_q;
  logic [DW-1:0]   data_rdata_q;
  logic            xfer_done;

  arb_pick #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .last_winner (last_winner_q),
    .winner      (pick)
  );

  // Next-state, grant and request-latch logic.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    lat_wr_d      = lat_wr_q;
    lat_wstrb_d   = lat_wstrb_q;
    lat_addr_d    = lat_addr_q;
    lat_wdata_d   = lat_wdata_q;

    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          grant_d = pick;
          state_d = ADDR;
          if (pick == GNT_DATA) begin
            lat_wr_d    = data_wr;
            lat_wstrb_d = data_wstrb;
            lat_addr_d  = data_addr;
            lat_wdata_d = data_wdata;
          end else begin
            // fetch is always a plain read
            lat_wr_d    = 1'b0;
            lat_wstrb_d = '0;
            lat_addr_d  = inst_addr;
            lat_wdata_d = '0;
          end
        end
      end
      ADDR: begin
        // a data beat in the accept cycle is too early and is ignored here
        if (mem_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          last_winner_d = grant_q;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, grant and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= GNT_DATA;
      last_winner_q <= GNT_INST;
      lat_wr_q      <= 1'b0;
      lat_wstrb_q   <= '0;
      lat_addr_q    <= '0;
      lat_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      lat_wr_q      <= lat_wr_d;
      lat_wstrb_q   <= lat_wstrb_d;
      lat_addr_q    <= lat_addr_d;
      lat_wdata_q   <= lat_wdata_d;
    end
  end

  // Completion decode and memory-side drive.
  always_comb begin
    xfer_done = (state_q == DATA) && mem_data_ok;
    inst_ok   = xfer_done && (grant_q == GNT_INST);
    data_ok   = xfer_done && (grant_q == GNT_DATA);
    mem_req   = (state_q == ADDR);
    mem_wr    = lat_wr_q;
    mem_wstrb = lat_wstrb_q;
    mem_addr  = lat_addr_q;
    mem_wdata = lat_wdata_q;
  end

  // Read-data holding registers, each loaded only on its own done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (inst_ok) begin
        inst_rdata_q <= mem_rdata;
      end
      if (data_ok) begin
        data_rdata_q <= mem_rdata;
      end
    end
  end

  // Read data is forwarded in the done cycle, held afterwards.
  always_comb begin
    inst_rdata = inst_ok ? mem_rdata : inst_rdata_q;
    data_rdata = data_ok ? mem_rdata : data_rdata_q;
  end

  // Stall requests for the hazard unit; depend only on req and ok.
  always_comb begin
    stall_inst = inst_req && !inst_ok;
    stall_data = data_req && !data_ok;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share all inputs:
// u_dut0 uses fixed data priority, u_dut1 alternates on ties.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic [31:0] i0_rdata, d0_rdata, m0_addr, m0_wdata;
  logic        i0_ok, d0_ok, m0_req, m0_wr, s0_inst, s0_data;
  logic [3:0]  m0_wstrb;
  logic [31:0] i1_rdata, d1_rdata, m1_addr, m1_wdata;
  logic        i1_ok, d1_ok, m1_req, m1_wr, s1_inst, s1_data;
  logic [3:0]  m1_wstrb;

  int n_chk;
  int n_fail;
  int ok_cnt;

  mem_port_arbiter #(.AW(32), .DW(32), .ROUND_ROBIN(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(i0_rdata), .inst_ok(i0_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(d0_rdata), .data_ok(d0_ok),
    .mem_req(m0_req), .mem_wr(m0_wr), .mem_wstrb(m0_wstrb), .mem_addr(m0_addr),
    .mem_wdata(m0_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .stall_inst(s0_inst), .stall_data(s0_data)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .ROUND_ROBIN(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(i1_rdata), .inst_ok(i1_ok),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(d1_rdata), .data_ok(d1_ok),
    .mem_req(m1_req), .mem_wr(m1_wr), .mem_wstrb(m1_wstrb), .mem_addr(m1_addr),
    .mem_wdata(m1_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .stall_inst(s1_inst), .stall_data(s1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_wstrb  = '0;
    data_addr   = '0;
    data_wdata  = '0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle_inputs();
    rst = 1'b1;

    // ---- reset state ----
    #12;
    check_eq("rst_mem_req", m0_req, 1'b0);
    check_eq("rst_mem_wr", m0_wr, 1'b0);
    check_eq("rst_inst_ok", i0_ok, 1'b0);
    check_eq("rst_data_ok", d0_ok, 1'b0);
    check_eq("rst_mem_addr", m0_addr, 32'h0);
    check_eq("rst_mem_wdata", m0_wdata, 32'h0);
    check_eq("rst_mem_wstrb", m0_wstrb, 4'h0);
    inst_req = 1'b1;
    #1;
    check_eq("rst_stall_inst", s0_inst, 1'b1);
    inst_req = 1'b0;
    #1;
    check_eq("rst_stall_inst_lo", s0_inst, 1'b0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // ---- inst read, zero-wait memory ----
    inst_addr = 32'hBFC0_0000;
    for (int c = 0; c < 4; c++) begin
      inst_req    = (c < 3);
      mem_addr_ok = (c == 1);
      mem_data_ok = (c == 2);
      mem_rdata   = (c == 2) ? 32'h2408_0001 : 32'hFFFF_FFFF;
      @(negedge clk);
      check_eq("t1_mem_req", m0_req, (c == 1));
      check_eq("t1_inst_ok", i0_ok, (c == 2));
      check_eq("t1_data_ok", d0_ok, 1'b0);
      check_eq("t1_stall_inst", s0_inst, (c < 2));
      if (c == 1) begin
        check_eq("t1_mem_wr", m0_wr, 1'b0);
        check_eq("t1_mem_addr", m0_addr, 32'hBFC0_0000);
      end
      if (c >= 2) check_eq("t1_inst_rdata", i0_rdata, 32'h2408_0001);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // ---- store with slow address acceptance ----
    data_wr    = 1'b1;
    data_wstrb = 4'b0011;
    data_addr  = 32'h8000_0004;
    data_wdata = 32'h0000_BEEF;
    ok_cnt     = 0;
    for (int c = 0; c < 7; c++) begin
      data_req    = (c < 6);
      mem_addr_ok = (c == 4);
      mem_data_ok = (c == 2) || (c == 5);
      mem_rdata   = 32'h5555_0000 + c;
      @(negedge clk);
      check_eq("t2_mem_req", m0_req, (c >= 1 && c <= 4));
      check_eq("t2_inst_ok", i0_ok, 1'b0);
      check_eq("t2_data_ok", d0_ok, (c == 5));
      check_eq("t2_stall_data", s0_data, (c < 5));
      if (c >= 1 && c <= 4) begin
        check_eq("t2_mem_wr", m0_wr, 1'b1);
        check_eq("t2_mem_wstrb", m0_wstrb, 4'b0011);
        check_eq("t2_mem_addr", m0_addr, 32'h8000_0004);
        check_eq("t2_mem_wdata", m0_wdata, 32'h0000_BEEF);
      end
      if (d0_ok) ok_cnt++;
      next_cycle();
    end
    check_eq("t2_data_ok_count", ok_cnt, 1);
    idle_inputs();
    next_cycle();

    // ---- tie with fixed data priority ----
    inst_addr = 32'h0000_0200;
    data_addr = 32'h0000_0100;
    for (int c = 0; c < 7; c++) begin
      data_req    = (c < 3);
      inst_req    = (c < 6);
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'hA000_0000 + c;
      @(negedge clk);
      check_eq("t3_mem_req", m0_req, (c == 1) || (c == 4));
      check_eq("t3_data_ok", d0_ok, (c == 2));
      check_eq("t3_inst_ok", i0_ok, (c == 5));
      if (c == 1) check_eq("t3_first_addr", m0_addr, 32'h0000_0100);
      if (c == 4) check_eq("t3_second_addr", m0_addr, 32'h0000_0200);
      if (c == 2) check_eq("t3_data_rdata", d0_rdata, 32'hA000_0002);
      if (c == 5) check_eq("t3_inst_rdata", i0_rdata, 32'hA000_0005);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // ---- tie with alternating priority, four transactions ----
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    next_cycle();
    inst_addr = 32'h0000_0300;
    data_addr = 32'h0000_0400;
    for (int c = 0; c < 13; c++) begin
      inst_req    = (c < 12);
      data_req    = (c < 12);
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      mem_rdata   = 32'hC000_0000 + c;
      @(negedge clk);
      check_eq("t4_mem_req", m1_req, (c % 3 == 1) && (c < 12));
      check_eq("t4_data_ok", d1_ok, (c == 2) || (c == 8));
      check_eq("t4_inst_ok", i1_ok, (c == 5) || (c == 11));
      if ((c % 3 == 1) && (c < 12))
        check_eq("t4_grant_addr", m1_addr, ((c / 3) % 2 == 0) ? 32'h0000_0400 : 32'h0000_0300);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // ---- async reset in the middle of DATA ----
    inst_req    = 1'b1;
    inst_addr   = 32'h0000_0500;
    mem_addr_ok = 1'b1;
    next_cycle();
    next_cycle();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = 32'h7777_7777;
    #1;
    check_eq("t5_pre_inst_ok", i0_ok, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_mem_req", m0_req, 1'b0);
    check_eq("t5_rst_inst_ok", i0_ok, 1'b0);
    check_eq("t5_rst_data_ok", d0_ok, 1'b0);
    check_eq("t5_rst_mem_addr", m0_addr, 32'h0);
    check_eq("t5_rst_stall_inst", s0_inst, 1'b1);
    #1;
    rst = 1'b0;
    idle_inputs();
    next_cycle();
    inst_addr = 32'h0000_0600;
    for (int c = 0; c < 4; c++) begin
      inst_req    = (c < 3);
      mem_addr_ok = (c == 1);
      mem_data_ok = (c == 2);
      mem_rdata   = (c == 2) ? 32'h0BAD_F00D : 32'h0;
      @(negedge clk);
      check_eq("t5_mem_req", m0_req, (c == 1));
      check_eq("t5_inst_ok", i0_ok, (c == 2));
      if (c == 1) check_eq("t5_mem_addr", m0_addr, 32'h0000_0600);
      if (c >= 2) check_eq("t5_inst_rdata", i0_rdata, 32'h0BAD_F00D);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // ---- data beat in the accept cycle is ignored ----
    data_addr = 32'h0000_0040;
    for (int c = 0; c < 4; c++) begin
      data_req    = (c < 3);
      mem_addr_ok = (c == 1);
      mem_data_ok = (c < 3);
      mem_rdata   = (c == 1) ? 32'hDEAD_0000 : (c == 2) ? 32'h1234_5678 : 32'h0;
      @(negedge clk);
      check_eq("t6_mem_req", m0_req, (c == 1));
      check_eq("t6_data_ok", d0_ok, (c == 2));
      check_eq("t6_inst_ok", i0_ok, 1'b0);
      if (c >= 2) check_eq("t6_data_rdata", d0_rdata, 32'h1234_5678);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
